// File: rtl/keypad_scanner_gen.sv
// Parametrised active-low matrix keypad scanner: 2-flop row sync, column scan, debounce, ghost reject.
// Typematic auto-repeat is built only when KEY_REPEAT_EN is defined.
module keypad_scanner_gen #(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int DEBOUNCE     = 15,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100,
   localparam int CW          = $clog2(ROWS*COLS)
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic [CW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_held,
   output logic            ghost
);

   localparam int CIW = $clog2(COLS);
   localparam int RIW = $clog2(ROWS);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DEB, S_PRESSED} state_t;

   state_t          state;
   logic [ROWS-1:0] sync1, row_s, cap;
   logic [CIW-1:0]  ci;
   logic [RIW-1:0]  ri;
   logic [1:0]      settle;
   logic [15:0]     cnt, rcnt;
   logic [3:0]      n_low;
   logic [RIW-1:0]  low_idx;
   logic            rel_done;
`ifdef KEY_REPEAT_EN
   logic [15:0]     rep_cnt;
   logic            rep_first;
`else
   logic            unused_repeat_cfg;
   assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

   always_comb begin
      n_low   = '0;
      low_idx = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         if (!row_s[i]) begin
            n_low   = n_low + 4'd1;
            low_idx = RIW'(i);
         end
      end
   end

   assign rel_done = (row_s != cap) && (rcnt == 16'(DEBOUNCE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         sync1     <= '1;
         row_s     <= '1;
         cap       <= '1;
         ci        <= '0;
         ri        <= '0;
         settle    <= '0;
         cnt       <= '0;
         rcnt      <= '0;
         col       <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         ghost     <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_cnt   <= '0;
         rep_first <= 1'b1;
`endif
      end else begin
         sync1     <= row;
         row_s     <= sync1;
         key_valid <= 1'b0;
         ghost     <= 1'b0;
         case (state)
            S_IDLE: begin
               col <= '0;
               if (row_s != '1) begin
                  state  <= S_SCAN;
                  ci     <= '0;
                  settle <= '0;
                  col    <= ~(COLS'(1));
               end
            end
            S_SCAN: begin
               // Three cycles per column: two cover the synchroniser delay after the strobe moves.
               if (settle != 2'd2) begin
                  settle <= settle + 2'd1;
               end else begin
                  settle <= '0;
                  if (n_low == 4'd1) begin
                     ri    <= low_idx;
                     cap   <= row_s;
                     cnt   <= '0;
                     state <= S_DEB;
                  end else begin
                     if (n_low > 4'd1) ghost <= 1'b1;
                     if (ci == CIW'(COLS - 1)) begin
                        state <= S_IDLE;
                        col   <= '0;
                     end else begin
                        ci  <= ci + 1'b1;
                        col <= ~(COLS'(1) << (ci + 1'b1));
                     end
                  end
               end
            end
            S_DEB: begin
               if (row_s == cap) begin
                  if (cnt == 16'(DEBOUNCE - 1)) begin
                     key_code  <= CW'(int'(ri) * COLS + int'(ci));
                     key_valid <= 1'b1;
                     key_held  <= 1'b1;
                     rcnt      <= '0;
                     cnt       <= '0;
                     state     <= S_PRESSED;
`ifdef KEY_REPEAT_EN
                     rep_cnt   <= '0;
                     rep_first <= 1'b1;
`endif
                  end else if (cnt != '1) begin
                     cnt <= cnt + 16'd1;
                  end
               end else begin
                  cnt   <= '0;
                  col   <= '0;
                  state <= S_IDLE;
               end
            end
            S_PRESSED: begin
               if (rel_done) begin
                  key_held <= 1'b0;
                  rcnt     <= '0;
                  col      <= '0;
                  state    <= S_IDLE;
`ifdef KEY_REPEAT_EN
                  rep_cnt   <= '0;
                  rep_first <= 1'b1;
`endif
               end else begin
                  if (row_s != cap) begin
                     if (rcnt != '1) rcnt <= rcnt + 16'd1;
                  end else begin
                     rcnt <= '0;
                  end
`ifdef KEY_REPEAT_EN
                  if (rep_first ? (rep_cnt == 16'(REPEAT_DELAY - 1))
                                : (rep_cnt == 16'(REPEAT_RATE - 1))) begin
                     key_valid <= 1'b1;
                     rep_cnt   <= '0;
                     rep_first <= 1'b0;
                  end else if (rep_cnt != '1) begin
                     rep_cnt <= rep_cnt + 16'd1;
                  end
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
